mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS CPU; sits beside the ALU in EX and owns the HI/LO architectural registers.
- Successor to the fixed 32-bit MD unit:
  - generic WIDTH;
  - configurable multiply latency;
  - true iterative radix-2 divider;
  - defined divide-by-zero and overflow results;
  - MADD/MSUB accumulate ops;
  - illegal-issue flag.
- busy|start stalls the pipeline upstream.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥8).
- MUL_LAT, 5, cycles busy is high for MULT/MULTU/MADD*/MSUB* (≥1).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all state immediately when 0.
- start, input, 1, issue strobe; md_op is sampled when start=1.
- md_op, input, 4, operation code.
- d1, input, WIDTH, rs operand (dividend / multiplicand / MT data).
- d2, input, WIDTH, rt operand (divisor / multiplier).
- busy, output, 1, registered; high while a multi-cycle op is in flight.
- md_out, output, WIDTH, combinational: LO when md_op=MFLO, HI when md_op=MFHI, else 0.
- illegal, output, 1, registered one-cycle pulse on a rejected issue.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, illegal=0, FSM=IDLE, counter=0. Any in-flight op is aborted; no partial write to HI/LO.
- Opcodes:
  - 0 NOP
  - 1 MULTU, 2 MULT
  - 3 DIVU, 4 DIV
  - 5 MFLO, 6 MFHI
  - 7 MTHI, 8 MTLO
  - 9 MADDU, 10 MADD, 11 MSUBU, 12 MSUB
  - 13–15 reserved (treated as NOP)
- FSM states: IDLE, MUL, DIV, FIX.
- Issue: start=1 with a multi-cycle op while IDLE.
  - Operands are latched at that edge.
  - busy goes 1 at that same edge.
- MUL path:
  - Full 2·WIDTH product is computed from the latched operands, signed or unsigned per op.
  - Counter loads MUL_LAT-1.
  - Busy stays high for exactly MUL_LAT cycles.
  - On the edge that ends the last cycle, {HI,LO} is written and busy falls:
    - MULT/MULTU: {HI,LO} = product.
    - MADD/MADDU: {HI,LO} = {HI,LO} + product, modulo 2^(2·WIDTH).
    - MSUB/MSUBU: {HI,LO} = {HI,LO} − product, modulo 2^(2·WIDTH).
  - The accumulate base is the HI/LO value at that final edge.
- DIV path:
  - Restoring shift-subtract on operand magnitudes, one quotient bit per cycle: WIDTH cycles in DIV.
  - Then one FIX cycle, which applies signs (DIV only).
  - Busy is high for WIDTH+1 cycles (33 at default); HI/LO are written on the edge leaving FIX.
  - LO = quotient truncated toward zero; HI = remainder, sign of dividend.
- Boundaries:
  - Divide by zero: LO = all ones, HI = d1. Same latency, no exception.
  - DIV overflow (d1 = −2^(WIDTH−1), d2 = −1): LO = −2^(WIDTH−1), HI = 0.
- MTHI/MTLO:
  - Single-cycle; writes d1 at the edge when start=1 and busy=0.
  - If busy=1: ignored, and illegal pulses.
- MFHI/MFLO:
  - Combinational read, legal at any time.
  - During busy they return the old HI/LO (the pipeline is stalled anyway).
- start with a multi-cycle op while busy=1: op is dropped, the in-flight op is unaffected, illegal pulses for 1 cycle.
- On the edge where busy falls, a new start is rejected; issue is accepted from the following edge.
- md_op ≠ 5/6 → md_out = 0.

Optional Feature:
- Macro: MD_ACCUM_EN.
- Defined: opcodes 9–12 perform MADD/MADDU/MSUB/MSUBU as above.
- Undefined: opcodes 9–12 are treated as NOP (no busy, HI/LO unchanged, illegal stays 0), and the accumulate adder is not synthesised.

Decomposition:
- Package md_pkg holds:
  - localparams for all opcodes (MD_NOP … MD_MSUB);
  - FSM state encodings;
  - a function is_long_op(op).
- Sub-module md_div_iter, parametrised by WIDTH:
  - inputs: start, signed_op, dividend, divisor;
  - outputs: done, quot, rem.
  - It contains the DIV/FIX iteration and the zero/overflow handling.
- Top level holds HI/LO, the multiplier pipeline counter, issue control and the illegal logic.

Test Plan:
- Reset mid-divide:
  - Stimulus: DIV 100/7, drop reset on cycle 10.
  - Response: busy=0, HI=LO=0 immediately; after release, MFLO=0.
- MULT (MUL_LAT=5):
  - Stimulus: d1=−3 (0xFFFFFFFD), d2=7.
  - Response: busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU / DIV:
  - DIVU 0xFFFFFFFF/16 → after 33 busy cycles, LO=0x0FFFFFFF, HI=0xF.
  - DIV −7/2 → LO=−3, HI=−1.
- Divide by zero and overflow:
  - DIV 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Illegal issue:
  - MTLO 0x1234 issued while busy → illegal=1 for one cycle, LO unchanged.
  - MULTU issued while busy → in-flight result is unaffected.
- MD_ACCUM_EN defined:
  - Stimulus: MTHI 0, MTLO 10, then MADD 3×4.
  - Response: LO=22, HI=0.
  - Undefined: the same sequence leaves LO=10, busy never rises.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM
// state encoding and small opcode-classification helpers.
// Optional feature macro: MD_ACCUM_EN (enables MADD/MADDU/MSUB/MSUBU).
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_MULT  = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_DIV   = 4'd4;
  localparam logic [3:0] MD_MFLO  = 4'd5;
  localparam logic [3:0] MD_MFHI  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADDU = 4'd9;
  localparam logic [3:0] MD_MADD  = 4'd10;
  localparam logic [3:0] MD_MSUBU = 4'd11;
  localparam logic [3:0] MD_MSUB  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_t;

  // Multi-cycle ops: these raise busy and occupy the FSM.
  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      MD_MULTU, MD_MULT, MD_DIVU, MD_DIV: is_long_op = 1'b1;
`ifdef MD_ACCUM_EN
      MD_MADDU, MD_MADD, MD_MSUBU, MD_MSUB: is_long_op = 1'b1;
`else
      MD_MADDU, MD_MADD, MD_MSUBU, MD_MSUB: is_long_op = 1'b0;
`endif
      default: is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    is_div_op = (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    is_signed_op = (op == MD_MULT) || (op == MD_DIV) ||
                   (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Iterative radix-2 restoring divider: WIDTH shift-subtract steps on the
// operand magnitudes, then one FIX cycle in which done=1 and quot/rem carry
// the sign-corrected result (plus divide-by-zero override).
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [CNTW-1:0]  cnt_r;
  logic             run_r, fix_r, neg_q_r, neg_r_r, dz_r;
  logic [WIDTH:0]   rem_sh, trial;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    rem_sh = {rem_r, quo_r[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_r};
  end

  // Operand capture, iteration and FIX-phase sequencing.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      cnt_r   <= '0;
      run_r   <= 1'b0;
      fix_r   <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      fix_r <= 1'b0;
      if (start) begin
        rem_r   <= '0;
        quo_r   <= (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_r   <= (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
        neg_q_r <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r_r <= signed_op && dividend[WIDTH-1];
        dz_r    <= (divisor == '0);
        cnt_r   <= CNTW'(WIDTH);
        run_r   <= 1'b1;
      end else if (run_r) begin
        // A clear top bit of trial means no borrow: the divisor fits.
        rem_r <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
        cnt_r <= cnt_r - CNTW'(1);
        if (cnt_r == CNTW'(1)) begin
          run_r <= 1'b0;
          fix_r <= 1'b1;
        end
      end
    end
  end

  assign done = fix_r;

  // Sign fix-up. With a zero divisor every trial succeeds, so rem_r ends up
  // holding |dividend| and re-applying the dividend sign returns d1 exactly;
  // only the quotient needs overriding. The -2^(W-1)/-1 overflow case falls
  // out naturally: magnitude 2^(W-1), negated, is again -2^(W-1), rem 0.
  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    quot = neg_q_r ? -quo_r : quo_r;
    rem  = neg_r_r ? -rem_r : rem_r;
    if (dz_r) quot = '1;
  end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the EX stage. Owns HI/LO, runs the
// fixed-latency multiplier countdown, issues divides to md_div_iter and
// flags rejected issues. Optional macro: MD_ACCUM_EN (MADD/MSUB family).
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             busy,
  output logic [WIDTH-1:0] md_out,
  output logic             illegal
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH - 1 : MUL_LAT - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_t          state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo, a_r, b_r;
  logic [3:0]         op_r;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_res;
  logic               issue, div_start, div_signed, div_done;
  logic [WIDTH-1:0]   div_quot, div_rem;

  assign issue      = start && (state == S_IDLE) && is_long_op(md_op);
  assign div_start  = issue && is_div_op(md_op);
  assign div_signed = is_signed_op(md_op);

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .signed_op (div_signed),
    .dividend  (d1),
    .divisor   (d2),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // Full-width product from the latched operands; truncation to 2*WIDTH
  // makes one multiplier serve both signed and unsigned ops.
  always_comb begin
    a_ext   = is_signed_op(op_r) ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    b_ext   = is_signed_op(op_r) ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    product = a_ext * b_ext;
  end

  // Value written to {HI,LO} when the multiply countdown expires.
  always_comb begin
`ifdef MD_ACCUM_EN
    case (op_r)
      MD_MADDU, MD_MADD: mul_res = {hi, lo} + product;
      MD_MSUBU, MD_MSUB: mul_res = {hi, lo} - product;
      default:           mul_res = product;
    endcase
`else
    mul_res = product;
`endif
  end

  // Issue control, HI/LO writes, latency counting and the illegal pulse.
  // NOTE: HI/LO are architectural state and are cleared by reset, not left to power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= MD_NOP;
      busy    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= start && busy &&
                 (is_long_op(md_op) || md_op == MD_MTHI || md_op == MD_MTLO);
      case (state)
        S_IDLE: begin
          if (issue) begin
            a_r  <= d1;
            b_r  <= d2;
            op_r <= md_op;
            busy <= 1'b1;
            if (is_div_op(md_op)) begin
              state <= S_DIV;
              cnt   <= CW'(WIDTH - 1);
            end else begin
              state <= S_MUL;
              cnt   <= CW'(MUL_LAT - 1);
            end
          end else if (start && md_op == MD_MTHI) begin
            hi <= d1;
          end else if (start && md_op == MD_MTLO) begin
            lo <= d1;
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= mul_res;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          if (div_done) begin
            {hi, lo} <= {div_rem, div_quot};
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational HI/LO read port.
  always_comb begin
    if (md_op == MD_MFLO)      md_out = lo;
    else if (md_op == MD_MFHI) md_out = hi;
    else                       md_out = '0;
  end

endmodule
